// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the sample FIFO read port, the UART transmitter and its status outputs.
// The master modport is the transmitter side; the slave modport is the FIFO/host side.
interface fifo_uart_tx_if;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_q;
    logic       fifo_rdreq;
    logic       uart_tx;
    logic       busy;
    logic       byte_done;

    modport master (
        input  tx_en, fifo_empty, fifo_q,
        output fifo_rdreq, uart_tx, busy, byte_done
    );

    modport slave (
        output tx_en, fifo_empty, fifo_q,
        input  fifo_rdreq, uart_tx, busy, byte_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the AD sample FIFO and sends each one as an 8N1 UART frame, LSB first.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 frames).
module fifo_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.master link
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] baud_cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             bit_end;
    logic             tx_n;
    logic             parity_n;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_bit <= 1'b0;
        else
            parity_bit <= parity_n;
    end
`endif

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        bit_end   = (baud_cnt == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        parity_n  = parity_bit;
`else
        parity_n  = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (link.tx_en && !link.fifo_empty)
                    state_n = S_READ;
            end
            S_READ: begin
                state_n = S_LOAD;
            end
            S_LOAD: begin
                shreg_n   = link.fifo_q;
                bit_idx_n = 3'd0;
                parity_n  = ^link.fifo_q;
                state_n   = S_START;
            end
            S_START: begin
                if (bit_end)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end)
                    state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end)
                    state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // The bit timer only runs in the timed line states and restarts on every state change.
        if (state_n != state || bit_end || state < S_START)
            cnt_n = '0;
        else
            cnt_n = baud_cnt + CNT_ONE;

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = parity_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    // Outputs are registered from next-state values so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            baud_cnt        <= '0;
            bit_idx         <= 3'd0;
            shreg           <= 8'h00;
            link.uart_tx    <= 1'b1;
            link.fifo_rdreq <= 1'b0;
            link.busy       <= 1'b0;
            link.byte_done  <= 1'b0;
        end else begin
            state           <= state_n;
            baud_cnt        <= cnt_n;
            bit_idx         <= bit_idx_n;
            shreg           <= shreg_n;
            link.uart_tx    <= tx_n;
            link.fifo_rdreq <= (state_n == S_READ);
            link.busy       <= (state_n != S_IDLE);
            link.byte_done  <= (state_n == S_STOP) && (cnt_n == CNT_LAST);
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a FIFO model feeds the DUT, a line monitor decodes frames,
// and each test compares decoded frames against a queue of expected bytes.
module tb_fifo_uart_tx;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * BAUD_DIV;

    typedef struct {
        logic [FRAME_BITS-1:0] bits;
        int                    bd_pos;
        int                    bd_count;
        bit                    stable;
        int                    gap;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fifo_uart_tx_if ifc ();

    fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .reset (reset),
        .link  (ifc)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on fifo_q the cycle after rdreq.
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign ifc.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (ifc.fifo_rdreq === 1'b1 && wr_ptr != rd_ptr) begin
            ifc.fifo_q <= fifo_mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    int rdreq_cnt     = 0;
    int underflow_cnt = 0;

    always @(negedge clk) begin
        if (ifc.fifo_rdreq === 1'b1) begin
            rdreq_cnt++;
            if (ifc.fifo_empty !== 1'b0)
                underflow_cnt++;
        end
    end

    // Line monitor: records mid-bit samples, byte_done position, bit stability and idle gap per frame.
    frame_t     got_q[$];
    frame_t     mon_f;
    int         mon_cyc        = 0;
    int         last_end       = -1000;
    int         frames_aborted = 0;
    logic       prev_tx;
    bit         aborted;

    always begin
        @(negedge clk);
        mon_cyc++;
        if (reset === 1'b0 && ifc.uart_tx === 1'b0) begin
            mon_f.gap      = mon_cyc - last_end - 1;
            mon_f.bits     = '0;
            mon_f.bd_pos   = 0;
            mon_f.bd_count = 0;
            mon_f.stable   = 1'b1;
            aborted        = 1'b0;
            prev_tx        = ifc.uart_tx;
            for (int c = 1; c <= FRAME_LEN; c++) begin
                if (c > 1) begin
                    @(negedge clk);
                    mon_cyc++;
                end
                if (reset !== 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                if ((c - 1) % BAUD_DIV != 0 && ifc.uart_tx !== prev_tx)
                    mon_f.stable = 1'b0;
                prev_tx = ifc.uart_tx;
                if ((c - 1) % BAUD_DIV == BAUD_DIV / 2)
                    mon_f.bits[(c - 1) / BAUD_DIV] = ifc.uart_tx;
                if (ifc.byte_done === 1'b1) begin
                    mon_f.bd_count++;
                    mon_f.bd_pos = c;
                end
            end
            if (aborted) begin
                frames_aborted++;
            end else begin
                last_end = mon_cyc;
                got_q.push_back(mon_f);
            end
        end
    end

    logic [7:0] exp_q[$];
    int         got_rd = 0;

    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic push_byte(input logic [7:0] d);
        fifo_mem[wr_ptr[7:0]] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (got_q.size() < target && n < budget);
        ok = (got_q.size() >= target);
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ifc.uart_tx === 1'b0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset      = 1'b1;
        ifc.tx_en  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (ifc.uart_tx !== 1'b1 || ifc.fifo_rdreq !== 1'b0 || ifc.busy !== 1'b0 || ifc.byte_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: tx=%b rdreq=%b busy=%b done=%b, required 1 0 0 0",
                         ifc.uart_tx, ifc.fifo_rdreq, ifc.busy, ifc.byte_done);
            end
        end
        reset = 1'b0;
        bad   = 0;
        repeat (200) begin
            @(negedge clk);
            if (ifc.uart_tx !== 1'b1 || ifc.busy !== 1'b0)
                bad++;
        end
        #1;
        checks++;
        if (rdreq_cnt != 0) begin
            errors++;
            $display("[TB] FAIL idle_rdreq: %0d pulses, required 0", rdreq_cnt);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL idle_line: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_single();
        int     base_rq, lat;
        bit     ok;
        frame_t f;
        logic [7:0] e;
        base_rq = rdreq_cnt;
        @(negedge clk);
        push_byte(8'h55);
        wait_start(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("[TB] FAIL single_latency: %0d clks, required 3", lat);
        end
        wait_frames(got_rd + 1, FRAME_LEN + 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_timeout: frames %0d, required %0d", got_q.size(), got_rd + 1);
        end
        checks++;
        if (rdreq_cnt - base_rq != 1) begin
            errors++;
            $display("[TB] FAIL single_rdreq: %0d pulses, required 1", rdreq_cnt - base_rq);
        end
        while (got_rd < got_q.size()) begin
            f = got_q[got_rd];
            got_rd++;
            e = exp_q.pop_front();
            checks++;
            if (f.bits !== frame_of(e)) begin
                errors++;
                $display("[TB] FAIL single_bits: got %b, required %b", f.bits, frame_of(e));
            end
            checks++;
            if (f.bd_count != 1 || f.bd_pos != FRAME_LEN || !f.stable) begin
                errors++;
                $display("[TB] FAIL single_timing: done_pos=%0d count=%0d stable=%0d, required %0d 1 1",
                         f.bd_pos, f.bd_count, f.stable, FRAME_LEN);
            end
        end
    endtask

    task automatic test_back_to_back();
        int     base_rq, base_got;
        bit     ok;
        frame_t f;
        logic [7:0] e;
        base_rq  = rdreq_cnt;
        base_got = got_q.size();
        @(negedge clk);
        push_byte(8'hA3);
        push_byte(8'h0D);
        push_byte(8'h0A);
        wait_frames(base_got + 3, 3 * FRAME_LEN + 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL burst_timeout: frames %0d, required %0d", got_q.size(), base_got + 3);
        end
        checks++;
        if (ifc.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL burst_busy_stop: busy=%b, required 1", ifc.busy);
        end
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst_busy_idle: busy=%b, required 0", ifc.busy);
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (rdreq_cnt - base_rq != 3) begin
            errors++;
            $display("[TB] FAIL burst_rdreq: %0d pulses, required 3", rdreq_cnt - base_rq);
        end
        while (got_rd < got_q.size()) begin
            f = got_q[got_rd];
            got_rd++;
            e = exp_q.pop_front();
            checks++;
            if (f.bits !== frame_of(e)) begin
                errors++;
                $display("[TB] FAIL burst_bits: got %b, required %b", f.bits, frame_of(e));
            end
            checks++;
            if (f.bd_count != 1 || f.bd_pos != FRAME_LEN || !f.stable) begin
                errors++;
                $display("[TB] FAIL burst_timing: done_pos=%0d count=%0d stable=%0d, required %0d 1 1",
                         f.bd_pos, f.bd_count, f.stable, FRAME_LEN);
            end
            if (got_rd > base_got + 1) begin
                checks++;
                if (f.gap != 3) begin
                    errors++;
                    $display("[TB] FAIL burst_gap: %0d clks, required 3", f.gap);
                end
            end
        end
    endtask

    task automatic test_tx_en_drop();
        int     base_rq, base_got, lat;
        bit     ok;
        frame_t f;
        logic [7:0] e;
        base_rq  = rdreq_cnt;
        base_got = got_q.size();
        @(negedge clk);
        push_byte(8'h7E);
        push_byte(8'h33);
        wait_start(lat);
        repeat (19) @(negedge clk);
        ifc.tx_en = 1'b0;
        wait_frames(base_got + 1, FRAME_LEN + 20, ok);
        repeat (50) @(negedge clk);
        #1;
        checks++;
        if (!ok || got_q.size() != base_got + 1) begin
            errors++;
            $display("[TB] FAIL txen_first_frame: frames %0d, required %0d", got_q.size(), base_got + 1);
        end
        checks++;
        if (rdreq_cnt - base_rq != 1 || ifc.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL txen_hold: rdreq=%0d busy=%b, required 1 0", rdreq_cnt - base_rq, ifc.busy);
        end
        @(negedge clk);
        ifc.tx_en = 1'b1;
        wait_start(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("[TB] FAIL txen_resume_latency: %0d clks, required 3", lat);
        end
        wait_frames(base_got + 2, FRAME_LEN + 20, ok);
        checks++;
        if (!ok || rdreq_cnt - base_rq != 2) begin
            errors++;
            $display("[TB] FAIL txen_second: frames %0d rdreq %0d, required %0d 2",
                     got_q.size(), rdreq_cnt - base_rq, base_got + 2);
        end
        while (got_rd < got_q.size()) begin
            f = got_q[got_rd];
            got_rd++;
            e = exp_q.pop_front();
            checks++;
            if (f.bits !== frame_of(e) || f.bd_pos != FRAME_LEN || !f.stable) begin
                errors++;
                $display("[TB] FAIL txen_frame: bits %b done_pos %0d, required %b %0d",
                         f.bits, f.bd_pos, frame_of(e), FRAME_LEN);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base_rq, base_got, base_ab, lat;
        logic [7:0] lost;
        base_rq  = rdreq_cnt;
        base_got = got_q.size();
        base_ab  = frames_aborted;
        @(negedge clk);
        push_byte(8'h41);
        wait_start(lat);
        repeat (44) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ifc.uart_tx !== 1'b1 || ifc.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midframe: tx=%b busy=%b, required 1 0", ifc.uart_tx, ifc.busy);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lost  = exp_q.pop_front();
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (rdreq_cnt - base_rq != 1 || got_q.size() != base_got) begin
            errors++;
            $display("[TB] FAIL reset_no_reread: rdreq %0d frames %0d (lost %02h), required 1 %0d",
                     rdreq_cnt - base_rq, got_q.size(), lost, base_got);
        end
        checks++;
        if (frames_aborted - base_ab != 1) begin
            errors++;
            $display("[TB] FAIL reset_truncated: %0d aborted frames, required 1", frames_aborted - base_ab);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int     base_got;
        bit     ok;
        frame_t f;
        logic [7:0] e;
        logic   want_par;
        base_got = got_q.size();
        @(negedge clk);
        push_byte(8'h55);
        push_byte(8'h07);
        wait_frames(base_got + 2, 2 * FRAME_LEN + 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL parity_timeout: frames %0d, required %0d", got_q.size(), base_got + 2);
        end
        while (got_rd < got_q.size()) begin
            f = got_q[got_rd];
            got_rd++;
            e = exp_q.pop_front();
            want_par = (e == 8'h07);
            checks++;
            if (f.bits[9] !== want_par) begin
                errors++;
                $display("[TB] FAIL parity_bit: got %b, required %b (byte %02h)", f.bits[9], want_par, e);
            end
            checks++;
            if (f.bits !== frame_of(e) || f.bd_pos != 110 || !f.stable) begin
                errors++;
                $display("[TB] FAIL parity_frame: bits %b done_pos %0d, required %b 110",
                         f.bits, f.bd_pos, frame_of(e));
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tx_en_drop();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (underflow_cnt != 0) begin
            errors++;
            $display("[TB] FAIL underflow: %0d reads while empty, required 0", underflow_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
